sprite_line_scheduler: RTL and testbench

Per-scanline sprite scheduler for the VGA sprite pipeline. During horizontal blanking it walks the sprite attribute table, a synchronous RAM of 20-bit sprite_info words. It selects, in table order, up to SLOTS enabled sprites whose vertical span covers the next scanline. It then commits them to a bank of slot registers that drive the per-slot mapper instances for the whole following line. Sprites beyond SLOTS on one line are dropped and flagged.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_line_hit.sv | 20 ++
 rtl/sprite_line_scheduler.sv | 122 ++++++++++++
 tb/tb_sprite_line_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite types and constants for the sprite pipeline
package sprite_pkg;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 48;
  localparam int INFO_W   = 20;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [8:0] y;
  } sprite_info_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } sched_state_t;

  function automatic sprite_info_t force_enable(input sprite_info_t s);
    sprite_info_t r;
    r    = s;
    r.en = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sprite_line_hit.sv
// rtl/sprite_line_hit.sv - combinational test of whether a sprite covers a scanline
module sprite_line_hit
  import sprite_pkg::*;
(
  input  sprite_info_t info_i,
  input  logic [9:0]   line_i,
  output logic         hit_o
);

  logic [9:0] top;
  logic [9:0] bot;
  logic       unused_x;

  // Y is at most 511, so the bottom row never exceeds 558 and fits in 10 bits.
  assign top      = {1'b0, info_i.y};
  assign bot      = top + 10'(SPRITE_H - 1);
  assign hit_o    = info_i.en && (line_i >= top) && (line_i <= bot);
  assign unused_x = ^info_i.x;

endmodule

// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - hblank scan of the attribute table into per-line mapper slots
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 64,
  parameter int SLOTS       = 8,
  localparam int AW         = $clog2(NUM_SPRITES),
  localparam int CW         = $clog2(SLOTS + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           line_start_i,
  input  logic [9:0]                     next_line_i,
  output logic [AW-1:0]                  tbl_addr_o,
  input  logic [INFO_W-1:0]              tbl_data_i,
  output logic [SLOTS-1:0][INFO_W-1:0]   slot_info_o,
  output logic [SLOTS-1:0]               slot_valid_o,
  output logic                           overflow_o,
  output logic                           busy_o,
  output logic                           done_o
);

  sched_state_t                   state_q;
  logic [AW-1:0]                  addr_q;
  logic [AW-1:0]                  eval_idx_q;
  logic                           eval_valid_q;
  logic [9:0]                     line_q;
  logic [CW-1:0]                  count_q;
  logic                           shadow_ovf_q;
  sprite_info_t                   shadow_q [SLOTS];
  logic [SLOTS-1:0][INFO_W-1:0]   slot_info_q;
  logic [SLOTS-1:0]               slot_valid_q;
  logic                           overflow_q;
  logic                           busy_q;
  logic                           done_q;

  sprite_info_t cur_info;
  logic         hit;

  assign cur_info = tbl_data_i;

  sprite_line_hit u_hit (
    .info_i (cur_info),
    .line_i (line_q),
    .hit_o  (hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      eval_idx_q   <= '0;
      eval_valid_q <= 1'b0;
      line_q       <= '0;
      count_q      <= '0;
      shadow_ovf_q <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        shadow_q[k]    <= '0;
        slot_info_q[k] <= '0;
      end
      slot_valid_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (line_start_i) begin
            line_q       <= next_line_i;
            count_q      <= '0;
            shadow_ovf_q <= 1'b0;
            for (int k = 0; k < SLOTS; k++) shadow_q[k] <= '0;
            addr_q       <= '0;
            eval_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          // Read data lags the address by one cycle; eval_idx_q names the entry on tbl_data_i.
          if (addr_q != AW'(NUM_SPRITES - 1)) addr_q <= addr_q + 1'b1;
          eval_valid_q <= 1'b1;
          eval_idx_q   <= addr_q;
          if (eval_valid_q) begin
            if (eval_idx_q == AW'(NUM_SPRITES - 1)) state_q <= COMMIT;
            if (hit) begin
              if (count_q == CW'(SLOTS)) begin
                shadow_ovf_q <= 1'b1;
                state_q      <= COMMIT;
              end else begin
                for (int k = 0; k < SLOTS; k++) begin
                  if (CW'(k) == count_q) shadow_q[k] <= force_enable(cur_info);
                end
                count_q <= count_q + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          for (int k = 0; k < SLOTS; k++) begin
            slot_valid_q[k] <= (CW'(k) < count_q);
            slot_info_q[k]  <= (CW'(k) < count_q) ? shadow_q[k] : '0;
          end
          overflow_q <= shadow_ovf_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tbl_addr_o   = addr_q;
  assign slot_info_o  = slot_info_q;
  assign slot_valid_o = slot_valid_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - directed bench with a table-walk reference model
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  localparam int N = 64;
  localparam int S = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 line_start = 1'b0;
  logic [9:0]           next_line = '0;
  logic [5:0]           tbl_addr;
  logic [19:0]          tbl_data;
  logic [S-1:0][19:0]   slot_info;
  logic [S-1:0]         slot_valid;
  logic                 overflow, busy, done;

  logic [19:0]          mem [N];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  int                   remain;
  int                   plan_lat;
  logic [S-1:0][19:0]   exp_info, pend_info;
  logic [S-1:0]         exp_valid, pend_valid;
  logic                 exp_ovf, pend_ovf, exp_busy, exp_done;

  sprite_line_scheduler #(.NUM_SPRITES(N), .SLOTS(S)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .line_start_i (line_start),
    .next_line_i  (next_line),
    .tbl_addr_o   (tbl_addr),
    .tbl_data_i   (tbl_data),
    .slot_info_o  (slot_info),
    .slot_valid_o (slot_valid),
    .overflow_o   (overflow),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= mem[tbl_addr];

  // Reference: walk the table in index order, keep the first S hits, stop at the (S+1)th.
  task automatic plan(input logic [9:0] nl);
    int n, y, l;
    n = 0;
    l = int'(nl);
    pend_info = '0;
    pend_valid = '0;
    pend_ovf = 1'b0;
    plan_lat = N + 3;
    for (int i = 0; i < N; i++) begin
      y = int'(mem[i][8:0]);
      if (mem[i][19] && l >= y && l < y + SPRITE_H) begin
        if (n < S) begin
          pend_info[n] = mem[i];
          pend_valid[n] = 1'b1;
          n++;
        end else begin
          pend_ovf = 1'b1;
          plan_lat = i + 4;
          break;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      remain = 0;
      exp_info = '0; exp_valid = '0; exp_ovf = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          exp_info = pend_info; exp_valid = pend_valid; exp_ovf = pend_ovf;
          exp_busy = 1'b0; exp_done = 1'b1;
        end
      end else if (line_start) begin
        plan(next_line);
        remain = plan_lat - 1;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== exp_busy || done !== exp_done || slot_valid !== exp_valid ||
          overflow !== exp_ovf || slot_info !== exp_info) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b valid=%h ovf=%b info=%h want busy=%b done=%b valid=%h ovf=%b info=%h",
                 $time, busy, done, slot_valid, overflow, slot_info,
                 exp_busy, exp_done, exp_valid, exp_ovf, exp_info);
      end
    end
  end

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic put(input int i, input bit en, input int x, input int y);
    mem[i] = {en, 10'(x), 9'(y)};
  endtask

  task automatic run_line(input logic [9:0] nl, input int pulse_at, output int done_cycle);
    @(negedge clk);
    line_start = 1'b1;
    next_line = nl;
    @(negedge clk);
    line_start = 1'b0;
    done_cycle = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      line_start = (c == pulse_at);
      if (done) begin
        done_cycle = c;
        break;
      end
    end
    line_start = 1'b0;
    if (done_cycle < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int extra;
    int line_tab [4];
    logic want_tab [4];
    clear_tbl();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", slot_valid, 0);
    chk("reset_info", slot_info, 0);
    chk("reset_flags", {overflow, busy, done}, 0);
    chk("reset_addr", tbl_addr, 0);

    clear_tbl();
    put(0, 1, 10, 100); put(5, 1, 50, 100); put(9, 1, 90, 100);
    run_line(10'd120, 0, dc);
    chk("basic_latency", dc, 67);
    chk("basic_valid", slot_valid, 8'h07);
    chk("basic_slot0", slot_info[0], 20'h81464);
    chk("basic_slot1", slot_info[1], 20'h86464);
    chk("basic_slot2", slot_info[2], 20'h8B464);
    chk("basic_upper_zero", slot_info[7:3], 0);
    chk("basic_ovf", overflow, 0);
    @(negedge clk);
    chk("basic_done_once", done, 0);

    clear_tbl();
    put(3, 1, 7, 100);
    line_tab = '{99, 100, 147, 148};
    want_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      run_line(10'(line_tab[k]), 0, dc);
      chk($sformatf("span_line_%0d", line_tab[k]), slot_valid, {7'b0, want_tab[k]});
    end
    put(3, 1, 7, 511);
    run_line(10'd558, 0, dc);
    chk("span_558_valid", slot_valid, 8'h01);
    chk("span_558_slot0", slot_info[0], 20'h80FFF);

    clear_tbl();
    for (int i = 0; i < 10; i++) put(i, 1, i * 20, 200);
    run_line(10'd220, 0, dc);
    chk("ovf_latency", dc, 12);
    chk("ovf_valid", slot_valid, 8'hFF);
    chk("ovf_flag", overflow, 1);
    chk("ovf_slot0", slot_info[0], 20'h800C8);
    chk("ovf_slot7", slot_info[7], 20'h918C8);

    clear_tbl();
    put(1, 0, 0, 100);
    run_line(10'd120, 10, dc);
    chk("zero_latency", dc, 67);
    chk("zero_valid", slot_valid, 0);
    chk("zero_info", slot_info, 0);
    chk("zero_ovf_cleared", overflow, 0);
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("busy_pulse_ignored", extra, 0);
    chk("idle_after_ignored", busy, 0);

    clear_tbl();
    put(2, 0, 30, 100); put(4, 1, 40, 100);
    run_line(10'd120, 0, dc);
    chk("disabled_valid", slot_valid, 8'h01);
    chk("disabled_slot0", slot_info[0], 20'h85064);

    clear_tbl();
    put(0, 1, 5, 100);
    @(negedge clk);
    line_start = 1'b1;
    next_line = 10'd120;
    @(negedge clk);
    line_start = 1'b0;
    for (int c = 2; c <= 30; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", slot_valid, 0);
    chk("rst_mid_info", slot_info, 0);
    chk("rst_mid_flags", {overflow, busy, done}, 0);
    chk("rst_mid_addr", tbl_addr, 0);
    run_line(10'd120, 0, dc);
    chk("post_rst_latency", dc, 67);
    chk("post_rst_valid", slot_valid, 8'h01);
    chk("post_rst_slot0", slot_info[0], 20'h80A64);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
